// File: rtl/ula_regbank_wb.sv
// Purpose: register bank, operand fetch and ULA-result writeback with one-deep result forwarding.
// Latency: operands are combinational in the issue cycle; the result reaches the bank on the 2nd edge after issue.
// Backpressure: none; one instruction per cycle, never stalls.
//
// Optional build macro: ULA_REGBANK_R0_ZERO_EN hardwires register 0 to zero
// (reads as 0, writes to it are suppressed, no forwarding from it).
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   issue_*             : instruction presented this cycle (op, sources, immediate, destination, write enable)
//   ula_op/ula_a/ula_b  : operands to the ULA (4'hF = hold, no new operation)
//   ula_result/zero/carry/neg : registered ULA outputs, valid the cycle after issue
//   wb_valid/wb_addr/wb_data  : writeback occurring this cycle
//   flag_z/flag_c/flag_n      : flags latched from the last completed legal instruction
//   err_illegal         : sticky, an illegal opcode was issued
//   dbg_addr/dbg_data   : raw register read, no forwarding
module ula_regbank_wb #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [3:0]        issue_op,
    input  logic [ADDR_W-1:0] issue_rs_a,
    input  logic [ADDR_W-1:0] issue_rs_b,
    input  logic              issue_imm_en,
    input  logic [7:0]        issue_imm,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_wr,
    output logic [3:0]        ula_op,
    output logic [7:0]        ula_a,
    output logic [7:0]        ula_b,
    input  logic [7:0]        ula_result,
    input  logic              ula_zero,
    input  logic              ula_carry,
    input  logic              ula_neg,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [7:0]        wb_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n,
    output logic              err_illegal,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

`ifdef ULA_REGBANK_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    localparam logic [3:0] OP_HOLD  = 4'hF;
    localparam logic [3:0] OP_LEGAL = 4'd4;   // highest legal opcode (MOV)

    // Instruction whose result the ULA is producing this cycle.
    typedef struct packed {
        logic              vld;
        logic              wr;
        logic [ADDR_W-1:0] rd;
    } pend_t;

    logic [7:0] regs [NUM_REGS];
    pend_t      pend_q;
    logic       issue_legal;
    logic       wr_en;
    logic       fwd_a;
    logic       fwd_b;

    // Register 0 is architecturally constant zero when the option is built in.
    function automatic logic is_r0z(input logic [ADDR_W-1:0] addr);
        is_r0z = R0_ZERO && (addr == '0);
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        in_range = (int'(addr) < NUM_REGS);
    endfunction

    // Raw bank read: unimplemented addresses and a hardwired r0 return zero.
    function automatic logic [7:0] reg_read(input logic [ADDR_W-1:0] addr);
        reg_read = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (in_range(addr) && !is_r0z(addr) && int'(addr) == i) begin
                reg_read = regs[i];
            end
        end
    endfunction

    assign issue_legal = (issue_op <= OP_LEGAL);

    // wb_valid reflects the write intent; the bank write additionally needs
    // an implemented address, and only a real write may be forwarded.
    assign wb_valid = pend_q.vld && pend_q.wr && !is_r0z(pend_q.rd);
    assign wr_en    = wb_valid && in_range(pend_q.rd);
    assign wb_addr  = pend_q.rd;
    assign wb_data  = ula_result;

    assign fwd_a = wr_en && (issue_rs_a == pend_q.rd);
    assign fwd_b = wr_en && !issue_imm_en && (issue_rs_b == pend_q.rd);

    always_comb begin
        ula_op = (issue_valid && issue_legal) ? issue_op : OP_HOLD;
        ula_a  = fwd_a ? ula_result : reg_read(issue_rs_a);
        if (issue_imm_en) begin
            ula_b = issue_imm;
        end else begin
            ula_b = fwd_b ? ula_result : reg_read(issue_rs_b);
        end
    end

    assign dbg_data = reg_read(dbg_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
            pend_q      <= '0;
            flag_z      <= 1'b1;
            flag_c      <= 1'b0;
            flag_n      <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            pend_q.vld <= issue_valid && issue_legal;
            pend_q.wr  <= issue_wr;
            pend_q.rd  <= issue_rd;

            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && int'(pend_q.rd) == i) begin
                    regs[i] <= ula_result;
                end
            end

            // Flags follow every completed legal op, including non-writing compares.
            if (pend_q.vld) begin
                flag_z <= ula_zero;
                flag_c <= ula_carry;
                flag_n <= ula_neg;
            end

            if (issue_valid && !issue_legal) begin
                err_illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ula_regbank_wb.sv
module tb_ula_regbank_wb;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] SHL = 4'd2;
    localparam logic [3:0] SHR = 4'd3;
    localparam logic [3:0] MOV = 4'd4;

`ifdef ULA_REGBANK_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0;
    logic [3:0] issue_op = 4'hF;
    logic [1:0] issue_rs_a = '0;
    logic [1:0] issue_rs_b = '0;
    logic       issue_imm_en = 1'b0;
    logic [7:0] issue_imm = '0;
    logic [1:0] issue_rd = '0;
    logic       issue_wr = 1'b0;
    logic [3:0] ula_op;
    logic [7:0] ula_a;
    logic [7:0] ula_b;
    logic [7:0] ula_result = 8'h00;
    logic       ula_zero = 1'b1;
    logic       ula_carry = 1'b0;
    logic       ula_neg = 1'b0;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       flag_z;
    logic       flag_c;
    logic       flag_n;
    logic       err_illegal;
    logic [1:0] dbg_addr = '0;
    logic [7:0] dbg_data;

    always #5 clk = ~clk;

    ula_regbank_wb #(.NUM_REGS(4), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_rs_a(issue_rs_a), .issue_rs_b(issue_rs_b),
        .issue_imm_en(issue_imm_en), .issue_imm(issue_imm),
        .issue_rd(issue_rd), .issue_wr(issue_wr),
        .ula_op(ula_op), .ula_a(ula_a), .ula_b(ula_b),
        .ula_result(ula_result), .ula_zero(ula_zero),
        .ula_carry(ula_carry), .ula_neg(ula_neg),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
        .err_illegal(err_illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // ULA behaviour: {carry, result}. SUB carry is the borrow.
    function automatic logic [8:0] ula_calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (op)
            ADD:     r = {1'b0, a} + {1'b0, b};
            SUB:     r = {(a < b), 8'(a - b)};
            SHL:     r = {a[7], a[6:0], 1'b0};
            SHR:     r = {a[0], 1'b0, a[7:1]};
            default: r = {1'b0, b};
        endcase
        return r;
    endfunction

    // Registered ULA; op 4'hF holds result and flags.
    logic [8:0] ula_t;
    always @(posedge clk) begin
        if (ula_op != 4'hF) begin
            ula_t = ula_calc(ula_op, ula_a, ula_b);
            ula_result <= ula_t[7:0];
            ula_carry  <= ula_t[8];
            ula_zero   <= (ula_t[7:0] == 8'h00);
            ula_neg    <= ula_t[7];
        end
    end

    // Sequential ISA model: arch = state after every instruction issued so far,
    // vis = state one instruction-cycle older (what the bank/flags show).
    logic [7:0] arch [4];
    logic [7:0] vis  [4];
    logic       a_z, a_c, a_n, a_err;
    logic       v_z, v_c, v_n;
    logic       l_vld, l_wr;
    logic [1:0] l_rd;
    logic [7:0] l_res;

    int n_run  = 0;
    int n_fail = 0;

    logic [1:0] dbg_sel = '0;
    logic       pk_en = 1'b0;
    logic [7:0] pk_reg = '0;
    logic [2:0] pk_fl = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            arch[i] = 8'h00;
            vis[i]  = 8'h00;
        end
        a_z = 1'b1; a_c = 1'b0; a_n = 1'b0; a_err = 1'b0;
        v_z = 1'b1; v_c = 1'b0; v_n = 1'b0;
        l_vld = 1'b0; l_wr = 1'b0; l_rd = '0; l_res = '0;
    endtask

    function automatic logic [7:0] rd_arch(input logic [1:0] a);
        return (R0Z && a == 2'd0) ? 8'h00 : arch[a];
    endfunction

    task automatic do_cycle(input logic v, input logic [3:0] op, input logic [1:0] ra,
                            input logic [1:0] rb, input logic ie, input logic [7:0] imm,
                            input logic [1:0] rd, input logic wr, input logic r);
        logic       legal;
        logic [7:0] ea, eb;
        logic       ewb;
        logic [8:0] t;
        issue_valid = v; issue_op = op; issue_rs_a = ra; issue_rs_b = rb;
        issue_imm_en = ie; issue_imm = imm; issue_rd = rd; issue_wr = wr;
        rst = r; dbg_addr = dbg_sel;
        @(negedge clk);
        legal = (op <= 4'd4);
        ea  = rd_arch(ra);
        eb  = ie ? imm : rd_arch(rb);
        ewb = l_vld && l_wr && !(R0Z && l_rd == 2'd0);
        chk("ula_op", 32'(ula_op), 32'((v && legal) ? op : 4'hF));
        chk("ula_a", 32'(ula_a), 32'(ea));
        chk("ula_b", 32'(ula_b), 32'(eb));
        chk("wb_valid", 32'(wb_valid), 32'(ewb));
        if (ewb) begin
            chk("wb_addr", 32'(wb_addr), 32'(l_rd));
            chk("wb_data", 32'(wb_data), 32'(l_res));
        end
        chk("flags_zcn", 32'({flag_z, flag_c, flag_n}), 32'({v_z, v_c, v_n}));
        chk("err_illegal", 32'(err_illegal), 32'(a_err));
        chk("dbg_data", 32'(dbg_data), 32'(vis[dbg_sel]));
        if (pk_en) begin
            chk("peek_reg", 32'(dbg_data), 32'(pk_reg));
            chk("peek_flags", 32'({flag_z, flag_c, flag_n}), 32'(pk_fl));
        end
        if (r) begin
            model_reset();
        end else begin
            v_z = a_z; v_c = a_c; v_n = a_n;
            for (int i = 0; i < 4; i++) vis[i] = arch[i];
            l_vld = v && legal; l_wr = wr; l_rd = rd;
            if (v && legal) begin
                t = ula_calc(op, ea, eb);
                l_res = t[7:0];
                if (wr && !(R0Z && rd == 2'd0)) arch[rd] = t[7:0];
                a_z = (t[7:0] == 8'h00); a_c = t[8]; a_n = t[7];
            end else if (v) begin
                a_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        do_cycle(1'b0, 4'hF, 2'd0, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    endtask

    // Idle cycle that also checks one register and the flags against constants.
    task automatic peek(input logic [1:0] addr, input logic [7:0] val, input logic [2:0] fl);
        dbg_sel = addr; pk_en = 1'b1; pk_reg = val; pk_fl = fl;
        idle();
        pk_en = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        for (int i = 0; i < 4; i++) peek(2'(i), 8'h00, 3'b100);

        // MOV 5 -> r1, idle, ADD r1+r1 -> r2.
        do_cycle(1, MOV, 2'd0, 2'd0, 1, 8'h05, 2'd1, 1, 0);
        idle();
        do_cycle(1, ADD, 2'd1, 2'd1, 0, 8'h00, 2'd2, 1, 0);
        idle(); idle();
        peek(2'd2, 8'h0A, 3'b000);

        // Back-to-back: MOV F0 -> r1, ADD r1 + 20 -> r1 (forwarded).
        do_cycle(1, MOV, 2'd0, 2'd0, 1, 8'hF0, 2'd1, 1, 0);
        do_cycle(1, ADD, 2'd1, 2'd0, 1, 8'h20, 2'd1, 1, 0);
        idle(); idle();
        peek(2'd1, 8'h10, 3'b010);

        // SUB negative, then a non-writing compare.
        do_cycle(1, MOV, 2'd0, 2'd0, 1, 8'h03, 2'd1, 1, 0);
        do_cycle(1, MOV, 2'd0, 2'd0, 1, 8'h07, 2'd2, 1, 0);
        do_cycle(1, SUB, 2'd1, 2'd2, 0, 8'h00, 2'd3, 1, 0);
        idle(); idle();
        peek(2'd3, 8'hFC, 3'b011);
        do_cycle(1, SUB, 2'd2, 2'd2, 0, 8'h00, 2'd3, 0, 0);
        idle(); idle();
        peek(2'd3, 8'hFC, 3'b100);

        // Illegal op: error sticks, nothing else changes.
        do_cycle(1, 4'h9, 2'd1, 2'd2, 0, 8'h00, 2'd1, 1, 0);
        idle();
        peek(2'd1, 8'h03, 3'b100);

        // Reset right after an issue discards the in-flight write.
        do_cycle(1, MOV, 2'd0, 2'd0, 1, 8'h33, 2'd2, 1, 0);
        do_cycle(0, 4'hF, 2'd0, 2'd0, 0, 8'h00, 2'd0, 0, 1);
        peek(2'd2, 8'h00, 3'b100);

        // Write to r0 followed immediately by a dependent read of r0.
        do_cycle(1, MOV, 2'd0, 2'd0, 1, 8'hAA, 2'd0, 1, 0);
        do_cycle(1, ADD, 2'd0, 2'd0, 1, 8'h01, 2'd1, 1, 0);
        idle(); idle();
        peek(2'd0, R0Z ? 8'h00 : 8'hAA, R0Z ? 3'b000 : 3'b001);
        peek(2'd1, R0Z ? 8'h01 : 8'hAB, R0Z ? 3'b000 : 3'b001);

        // Randomized traffic, including illegal ops, idles and occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            dbg_sel = 2'($urandom_range(0, 3));
            do_cycle(($urandom_range(0, 4) != 0), op,
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                     2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
